// File: rtl/led_scan_pkg.sv
// Shared constants and types for the 8x8 LED matrix scan driver.
package led_scan_pkg;
    localparam int NUM_COLS = 8;
    localparam int NUM_ROWS = 8;
    localparam int SEL_W    = 3;

    localparam logic [7:0] DEC_ALL_OFF = 8'hFF;

    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [7:0]       dec_t;
endpackage

// File: rtl/decoder_3to8_n.sv
// 74HC138-style 3-to-8 decoder: two active-low enables, one active-high enable,
// active-low one-cold outputs.
module decoder_3to8_n
    import led_scan_pkg::*;
(
    input  sel_t       sel,
    input  logic [1:0] en_n,
    input  logic       en,
    output dec_t       dec_n
);

    always_comb begin
        dec_n = DEC_ALL_OFF;
        if (en_n == 2'b00 && en) begin
            dec_n[sel] = 1'b0;
        end
    end

endmodule

// File: rtl/led_matrix_scan_driver.sv
// 8x8 LED matrix scan driver: prescaler, cascaded column/row counters, two decoders
// and the column extender/AND array. Define LED_OUT_REG_EN to register led_matrix.
module led_matrix_scan_driver
    import led_scan_pkg::*;
#(
    parameter int SCAN_DIV = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 col_en_n,
    input  logic                       col_en,
    input  logic [1:0]                 row_en_n,
    input  logic                       row_en,
    output logic [SEL_W-1:0]           col_sel,
    output logic [SEL_W-1:0]           row_sel,
    output logic [7:0]                 col_dec_n,
    output logic [7:0]                 row_dec_n,
    output logic [NUM_COLS*NUM_ROWS-1:0] led_matrix
);

    // 8 bits covers the full 1..256 divide range (terminal count 0..255).
    localparam logic [7:0] PRESC_MAX = 8'(SCAN_DIV - 1);

    logic [7:0] presc_q, presc_d;
    sel_t       col_q, col_d;
    sel_t       row_q, row_d;
    logic       step;

    assign step = (presc_q == PRESC_MAX);

    always_comb begin
        presc_d = step ? 8'd0 : presc_q + 8'd1;
        col_d   = col_q;
        row_d   = row_q;
        if (step) begin
            col_d = col_q + 3'd1;
            if (col_q == 3'd7) begin
                row_d = row_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= 8'd0;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            presc_q <= presc_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    assign col_sel = col_q;
    assign row_sel = row_q;

    decoder_3to8_n u_col_dec (
        .sel   (col_q),
        .en_n  (col_en_n),
        .en    (col_en),
        .dec_n (col_dec_n)
    );

    decoder_3to8_n u_row_dec (
        .sel   (row_q),
        .en_n  (row_en_n),
        .en    (row_en),
        .dec_n (row_dec_n)
    );

    logic [NUM_COLS*NUM_ROWS-1:0] led_comb;

    // Each column's select bit is widened to a full word and gates the row pattern.
    for (genvar k = 0; k < NUM_COLS; k++) begin : g_col
        assign led_comb[k*NUM_ROWS +: NUM_ROWS] = row_dec_n & ~{NUM_ROWS{col_dec_n[k]}};
    end

`ifdef LED_OUT_REG_EN
    logic [NUM_COLS*NUM_ROWS-1:0] led_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q <= '0;
        end else begin
            led_q <= led_comb;
        end
    end

    assign led_matrix = led_q;
`else
    assign led_matrix = led_comb;
`endif

endmodule

// File: tb/tb_led_matrix_scan_driver.sv
// Scoreboard bench for led_matrix_scan_driver (SCAN_DIV=1 and SCAN_DIV=4 instances).
module tb_led_matrix_scan_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  col_en_n = 2'b00;
    logic        col_en = 1'b1;
    logic [1:0]  row_en_n = 2'b00;
    logic        row_en = 1'b1;

    logic [2:0]  col_sel, row_sel, col_sel4, row_sel4;
    logic [7:0]  col_dec_n, row_dec_n, col_dec_n4, row_dec_n4;
    logic [63:0] led_matrix, led_matrix4;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [2:0]  col;
        logic [2:0]  row;
        logic [63:0] led;
    } exp_t;

    exp_t sb[$];
    exp_t sb4[$];
    exp_t e;

    // Reference state for each instance.
    int          m_presc, m4_presc;
    logic [2:0]  m_col, m_row, m4_col, m4_row;
    logic [63:0] m_led_reg, m4_led_reg;

    always #5 clk = ~clk;

    led_matrix_scan_driver #(.SCAN_DIV(1)) dut (
        .clk(clk), .rst(rst),
        .col_en_n(col_en_n), .col_en(col_en),
        .row_en_n(row_en_n), .row_en(row_en),
        .col_sel(col_sel), .row_sel(row_sel),
        .col_dec_n(col_dec_n), .row_dec_n(row_dec_n),
        .led_matrix(led_matrix)
    );

    led_matrix_scan_driver #(.SCAN_DIV(4)) dut4 (
        .clk(clk), .rst(rst),
        .col_en_n(col_en_n), .col_en(col_en),
        .row_en_n(row_en_n), .row_en(row_en),
        .col_sel(col_sel4), .row_sel(row_sel4),
        .col_dec_n(col_dec_n4), .row_dec_n(row_dec_n4),
        .led_matrix(led_matrix4)
    );

    function automatic logic [7:0] dec8(input logic [2:0] s, input logic [1:0] en_n, input logic en);
        logic [7:0] d;
        d = 8'hFF;
        if (en_n == 2'b00 && en == 1'b1) d = ~(8'h01 << s);
        return d;
    endfunction

    function automatic logic [63:0] led_model(input logic [2:0] c, input logic [2:0] r);
        logic [63:0] v;
        logic [7:0]  cd, rd;
        cd = dec8(c, col_en_n, col_en);
        rd = dec8(r, row_en_n, row_en);
        v = '0;
        for (int k = 0; k < 8; k++) v[8*k +: 8] = cd[k] ? 8'h00 : rd;
        return v;
    endfunction

    // Advance the reference models across one rising edge.
    task automatic model_edge();
        if (rst) begin
            m_presc = 0; m_col = 0; m_row = 0; m_led_reg = '0;
            m4_presc = 0; m4_col = 0; m4_row = 0; m4_led_reg = '0;
        end else begin
            m_led_reg  = led_model(m_col, m_row);
            m4_led_reg = led_model(m4_col, m4_row);
            if (m_col == 3'd7) m_row = m_row + 3'd1;
            m_col = m_col + 3'd1;
            if (m4_presc == 3) begin
                m4_presc = 0;
                if (m4_col == 3'd7) m4_row = m4_row + 3'd1;
                m4_col = m4_col + 3'd1;
            end else begin
                m4_presc = m4_presc + 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic push_expected();
        exp_t x;
        x.col = m_col;
        x.row = m_row;
`ifdef LED_OUT_REG_EN
        x.led = m_led_reg;
`else
        x.led = led_model(m_col, m_row);
`endif
        sb.push_back(x);
        x.col = m4_col;
        x.row = m4_row;
`ifdef LED_OUT_REG_EN
        x.led = m4_led_reg;
`else
        x.led = led_model(m4_col, m4_row);
`endif
        sb4.push_back(x);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        col_en_n = 2'b00; col_en = 1'b1; row_en_n = 2'b00; row_en = 1'b1;
        tick(); tick();
        rst = 1'b0;
        push_expected();
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (col_sel !== e.col || row_sel !== e.row || led_matrix !== e.led) begin
            failures++;
            $display("FAIL reset_state: got col=%0d row=%0d led=%h, want col=%0d row=%0d led=%h",
                     col_sel, row_sel, led_matrix, e.col, e.row, e.led);
        end
        void'(sb4.pop_front());
        checks++;
        if (col_dec_n !== 8'hFE || row_dec_n !== 8'hFE) begin
            failures++;
            $display("FAIL reset_decoders: got col_dec_n=%h row_dec_n=%h, want FE FE", col_dec_n, row_dec_n);
        end
        checks++;
`ifdef LED_OUT_REG_EN
        if (led_matrix !== 64'h0) begin
            failures++;
            $display("FAIL reset_led_reg: got %h, want 0", led_matrix);
        end
`else
        if (led_matrix[7:0] !== 8'hFE || led_matrix[63:8] !== 56'h0) begin
            failures++;
            $display("FAIL reset_led: got %h, want 00000000000000fe", led_matrix);
        end
`endif
    endtask

    task automatic test_col_scan();
        for (int i = 1; i <= 8; i++) begin
            tick();
            push_expected();
            @(negedge clk);
            e = sb.pop_front();
            void'(sb4.pop_front());
            checks++;
            if (col_sel !== e.col || row_sel !== e.row || led_matrix !== e.led) begin
                failures++;
                $display("FAIL col_scan[%0d]: got col=%0d row=%0d led=%h, want col=%0d row=%0d led=%h",
                         i, col_sel, row_sel, led_matrix, e.col, e.row, e.led);
            end
        end
        checks++;
        if (col_sel !== 3'd0 || row_sel !== 3'd1) begin
            failures++;
            $display("FAIL col_wrap: got col=%0d row=%0d, want col=0 row=1", col_sel, row_sel);
        end
    endtask

    task automatic test_frame();
        rst = 1'b1; tick(); rst = 1'b0;
        void'(sb.size());
        for (int i = 1; i <= 64; i++) begin
            tick();
            push_expected();
            @(negedge clk);
            e = sb.pop_front();
            void'(sb4.pop_front());
            checks++;
            if (col_sel !== e.col || row_sel !== e.row || led_matrix !== e.led) begin
                failures++;
                $display("FAIL frame[%0d]: got col=%0d row=%0d led=%h, want col=%0d row=%0d led=%h",
                         i, col_sel, row_sel, led_matrix, e.col, e.row, e.led);
            end
`ifndef LED_OUT_REG_EN
            if (i == 43) begin
                checks++;
                if (col_sel !== 3'd3 || row_sel !== 3'd5 || led_matrix[31:24] !== 8'hDF) begin
                    failures++;
                    $display("FAIL frame_word3: got col=%0d row=%0d word3=%h, want col=3 row=5 word3=df",
                             col_sel, row_sel, led_matrix[31:24]);
                end
            end
`endif
        end
        checks++;
        if (col_sel !== 3'd0 || row_sel !== 3'd0) begin
            failures++;
            $display("FAIL frame_wrap: got col=%0d row=%0d, want col=0 row=0", col_sel, row_sel);
        end
    endtask

    task automatic test_enables();
        tick(); tick();
        row_en = 1'b0;
        #1;
        push_expected();
        #1;
        e = sb.pop_front();
        void'(sb4.pop_front());
        checks++;
        if (led_matrix !== e.led) begin
            failures++;
            $display("FAIL row_disabled: got led=%h, want %h", led_matrix, e.led);
        end
`ifndef LED_OUT_REG_EN
        checks++;
        if (led_matrix[8*col_sel +: 8] !== 8'hFF || (led_matrix & ~(64'hFF << (8*col_sel))) !== 64'h0) begin
            failures++;
            $display("FAIL row_disabled_word: got led=%h, want FF only in column %0d", led_matrix, col_sel);
        end
`endif
        row_en = 1'b1;
        col_en_n = 2'b10;
        for (int i = 0; i < 3; i++) begin
            tick();
            push_expected();
            @(negedge clk);
            e = sb.pop_front();
            void'(sb4.pop_front());
            checks++;
            if (led_matrix !== 64'h0 || led_matrix !== e.led) begin
                failures++;
                $display("FAIL col_disabled[%0d]: got led=%h, want %h", i, led_matrix, e.led);
            end
        end
        col_en_n = 2'b00;
    endtask

    task automatic test_reset_midframe();
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 21; i++) tick();
        checks++;
        if (col_sel !== 3'd5 || row_sel !== 3'd2) begin
            failures++;
            $display("FAIL midframe_pos: got col=%0d row=%0d, want col=5 row=2", col_sel, row_sel);
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            push_expected();
            @(negedge clk);
            e = sb.pop_front();
            void'(sb4.pop_front());
            checks++;
            if (col_sel !== 3'd0 || row_sel !== 3'd0 || led_matrix !== e.led) begin
                failures++;
                $display("FAIL midframe_rst[%0d]: got col=%0d row=%0d led=%h, want col=0 row=0 led=%h",
                         i, col_sel, row_sel, led_matrix, e.led);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_scan_div4();
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            push_expected();
            @(negedge clk);
            void'(sb.pop_front());
            e = sb4.pop_front();
            checks++;
            if (col_sel4 !== e.col || row_sel4 !== e.row || led_matrix4 !== e.led) begin
                failures++;
                $display("FAIL div4[%0d]: got col=%0d row=%0d led=%h, want col=%0d row=%0d led=%h",
                         i, col_sel4, row_sel4, led_matrix4, e.col, e.row, e.led);
            end
            if (i == 4 || i == 7) begin
                checks++;
                if (col_sel4 !== 3'(i / 4)) begin
                    failures++;
                    $display("FAIL div4_step[%0d]: got col=%0d, want %0d", i, col_sel4, i / 4);
                end
            end
        end
    endtask

    initial begin
        m_presc = 0; m4_presc = 0;
        m_col = 0; m_row = 0; m4_col = 0; m4_row = 0;
        m_led_reg = '0; m4_led_reg = '0;
        test_reset();
        test_col_scan();
        test_frame();
        test_enables();
        test_reset_midframe();
        test_scan_div4();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
